// File: rtl/ad7476_spi_master_if.sv
// Signal bundle between the AD7476 SPI master and its neighbours: the
// ADC pins (cs_n_o, sck_o, miso_i) and the sample/handshake signals.
// With ADC_AUTO_TRIG_EN defined, the bundle also carries auto_en_i.
interface ad7476_spi_master_if;
    logic        start_i;
    logic        miso_i;
`ifdef ADC_AUTO_TRIG_EN
    logic        auto_en_i;
`endif
    logic        cs_n_o;
    logic        sck_o;
    logic        busy_o;
    logic [11:0] sample_o;
    logic [15:0] raw_o;
    logic        sample_valid_o;
    logic        fmt_err_o;
    logic        start_drop_o;

    // The controller side.
    modport master (
        input  start_i,
        input  miso_i,
`ifdef ADC_AUTO_TRIG_EN
        input  auto_en_i,
`endif
        output cs_n_o,
        output sck_o,
        output busy_o,
        output sample_o,
        output raw_o,
        output sample_valid_o,
        output fmt_err_o,
        output start_drop_o
    );

    // The side that requests conversions, serves MISO and consumes samples.
    modport slave (
        output start_i,
        output miso_i,
`ifdef ADC_AUTO_TRIG_EN
        output auto_en_i,
`endif
        input  cs_n_o,
        input  sck_o,
        input  busy_o,
        input  sample_o,
        input  raw_o,
        input  sample_valid_o,
        input  fmt_err_o,
        input  start_drop_o
    );
endinterface

// File: rtl/ad7476_spi_master.sv
// SPI master for an AD7476-class ADC. Each conversion is one 16-bit frame
// (4 leading zeros, then 12 data bits, MSB first). MISO is captured on every
// SCK rising transition. The 16-bit frame is published with a one-cycle
// sample_valid_o strobe.
// Optional macro ADC_AUTO_TRIG_EN adds a free-running sample-period timer.
// The timer is enabled by auto_en_i, and its start pulse is ORed with start_i.
module ad7476_spi_master #(
    parameter int CLK_DIV      = 4,  // clk_i cycles per SCK half-period / CS setup
    parameter int QUIET_CYCLES = 8   // minimum cs_n_o-high cycles between frames
`ifdef ADC_AUTO_TRIG_EN
    ,
    parameter int SAMPLE_PERIOD = 200  // clk_i cycles between automatic starts
`endif
) (
    input logic                  clk_i,
    input logic                  rst_i,
    ad7476_spi_master_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SCK_LOW,
        S_SCK_HIGH,
        S_QUIET
    } state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);

    state_t      r_state, w_state_nx;
    logic [7:0]  r_div_cnt, w_div_nx;      // phase timer; QUIET reuses it
    logic [3:0]  r_bit_cnt, w_bit_nx;      // completed SCK periods in this frame
    logic [15:0] r_shift, w_shift_nx;
    logic [15:0] r_raw, w_raw_nx;
    logic        r_cs_n, w_cs_n_nx;
    logic        r_sck, w_sck_nx;
    logic        r_busy, w_busy_nx;
    logic        r_valid, w_valid_nx;
    logic        r_fmt_err, w_fmt_err_nx;
    logic        r_drop, w_drop_nx;
    logic        w_start;

`ifdef ADC_AUTO_TRIG_EN
    localparam logic [15:0] PERIOD_LAST = 16'(SAMPLE_PERIOD - 1);

    logic [15:0] r_period_cnt;
    logic        r_auto_pulse;

    // Sample-period timer: cleared while disabled; emits one pulse per period.
    always_ff @(posedge clk_i) begin
        if (rst_i || !bus.auto_en_i) begin
            r_period_cnt <= '0;
            r_auto_pulse <= 1'b0;
        end else if (r_period_cnt == PERIOD_LAST) begin
            r_period_cnt <= '0;
            r_auto_pulse <= 1'b1;
        end else begin
            r_period_cnt <= r_period_cnt + 16'd1;
            r_auto_pulse <= 1'b0;
        end
    end

    assign w_start = bus.start_i | (r_auto_pulse & bus.auto_en_i);
`else
    assign w_start = bus.start_i;
`endif

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        // NOTE: every target gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        w_state_nx   = r_state;
        w_div_nx     = r_div_cnt;
        w_bit_nx     = r_bit_cnt;
        w_shift_nx   = r_shift;
        w_raw_nx     = r_raw;
        w_cs_n_nx    = r_cs_n;
        w_sck_nx     = r_sck;
        w_busy_nx    = r_busy;
        w_valid_nx   = 1'b0;
        w_fmt_err_nx = 1'b0;
        w_drop_nx    = w_start && (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nx = S_CS_SETUP;
                    w_cs_n_nx  = 1'b0;
                    w_busy_nx  = 1'b1;
                    w_div_nx   = '0;
                    w_bit_nx   = '0;
                end
            end
            S_CS_SETUP: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_nx   = '0;
                    w_state_nx = S_SCK_LOW;
                end else begin
                    w_div_nx = r_div_cnt + 8'd1;
                end
            end
            S_SCK_LOW: begin
                // The ADC changes MISO after the falling edge, so it is
                // stable here and is sampled as SCK rises.
                if (r_div_cnt == DIV_LAST) begin
                    w_div_nx   = '0;
                    w_sck_nx   = 1'b1;
                    w_shift_nx = {r_shift[14:0], bus.miso_i};
                    w_state_nx = S_SCK_HIGH;
                end else begin
                    w_div_nx = r_div_cnt + 8'd1;
                end
            end
            S_SCK_HIGH: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_nx = '0;
                    w_sck_nx = 1'b0;
                    w_bit_nx = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd15) begin
                        w_cs_n_nx    = 1'b1;
                        w_raw_nx     = r_shift;
                        w_valid_nx   = 1'b1;
                        w_fmt_err_nx = (r_shift[15:12] != 4'd0);
                        w_state_nx   = S_QUIET;
                    end else begin
                        w_state_nx = S_SCK_LOW;
                    end
                end else begin
                    w_div_nx = r_div_cnt + 8'd1;
                end
            end
            S_QUIET: begin
                if (r_div_cnt == QUIET_LAST) begin
                    w_div_nx   = '0;
                    w_busy_nx  = 1'b0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_div_nx = r_div_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and clears the sample.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, whatever the statement order.
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_raw     <= '0;
            r_cs_n    <= 1'b1;
            r_sck     <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_fmt_err <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_div_cnt <= w_div_nx;
            r_bit_cnt <= w_bit_nx;
            r_shift   <= w_shift_nx;
            r_raw     <= w_raw_nx;
            r_cs_n    <= w_cs_n_nx;
            r_sck     <= w_sck_nx;
            r_busy    <= w_busy_nx;
            r_valid   <= w_valid_nx;
            r_fmt_err <= w_fmt_err_nx;
            r_drop    <= w_drop_nx;
        end
    end

    assign bus.cs_n_o         = r_cs_n;
    assign bus.sck_o          = r_sck;
    assign bus.busy_o         = r_busy;
    assign bus.raw_o          = r_raw;
    assign bus.sample_o       = r_raw[11:0];
    assign bus.sample_valid_o = r_valid;
    assign bus.fmt_err_o      = r_fmt_err;
    assign bus.start_drop_o   = r_drop;

endmodule

// File: tb/tb_ad7476_spi_master.sv
// Directed bench for ad7476_spi_master. The bench contains an ADC slave model
// that serves MISO. A frame-level reference computes every output from the
// cycle offset since the accepted start. A per-cycle compare checks the DUT
// against that reference. Literal checks pin the frame timing and data.
module tb_ad7476_spi_master;

    localparam int CD        = 4;
    localparam int QC        = 8;
    localparam int FRAME     = 33 * CD;        // cs_n low cycles; valid offset
    localparam int BUSY_LEN  = FRAME + QC;     // busy drops at this offset

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        chk_on = 1'b0;
    logic [15:0] adc_word = 16'h0000;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    ad7476_spi_master_if bus();

    ad7476_spi_master #(.CLK_DIV(CD), .QUIET_CYCLES(QC)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ADC slave: MSB presented while CS is low, next bit after each SCK fall.
    logic adc_prev_sck = 1'b0;
    int   adc_idx = 0;
    always @(negedge clk) begin
        adc_prev_sck <= bus.sck_o;
        if (bus.cs_n_o !== 1'b0) begin
            adc_idx    <= 0;
            bus.miso_i <= 1'b0;
        end else if (adc_prev_sck && !bus.sck_o) begin
            adc_idx    <= adc_idx + 1;
            bus.miso_i <= (adc_idx < 15) ? adc_word[14 - adc_idx] : 1'b0;
        end else begin
            bus.miso_i <= (adc_idx < 16) ? adc_word[15 - adc_idx] : 1'b0;
        end
    end

    // Reference: an accepted start at edge t0 defines the whole frame as a
    // function of the offset d = edge - t0.
    logic        m_active = 1'b0;
    int          m_t0 = 0;
    logic [15:0] m_word = 16'h0000;
    logic [15:0] m_raw = 16'h0000;
    logic        m_valid = 1'b0;
    logic        m_drop = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        m_valid <= 1'b0;
        m_drop  <= 1'b0;
        if (rst_i) begin
            m_active <= 1'b0;
            m_raw    <= 16'h0000;
        end else begin
            if (m_active && (cyc - m_t0 == FRAME)) begin
                m_valid <= 1'b1;
                m_raw   <= m_word;
            end
            if (bus.start_i) begin
                if (!m_active || (cyc - m_t0 > BUSY_LEN)) begin
                    m_active <= 1'b1;
                    m_t0     <= cyc;
                    m_word   <= adc_word;
                end else begin
                    m_drop <= 1'b1;
                end
            end
        end
    end

    function automatic logic [63:0] exp_vec();
        int   d;
        logic e_cs_n, e_sck, e_busy, e_fmt;
        d      = cyc - 1 - m_t0;
        e_cs_n = 1'b1;
        e_sck  = 1'b0;
        e_busy = 1'b0;
        if (m_active) begin
            e_cs_n = !(d < FRAME);
            e_busy = (d < BUSY_LEN);
            e_sck  = (d >= 2 * CD) && (d < FRAME) && (((d - 2 * CD) % (2 * CD)) < CD);
        end
        e_fmt = m_valid && (m_raw[15:12] != 4'd0);
        return {30'd0, e_cs_n, e_sck, e_busy, m_valid, e_fmt, m_drop, m_raw[11:0], m_raw};
    endfunction

    // Per-cycle compare against the reference.
    always @(negedge clk) begin
        if (chk_on) begin
            check($sformatf("cycle_%0d", cyc),
                  {30'd0, bus.cs_n_o, bus.sck_o, bus.busy_o, bus.sample_valid_o,
                   bus.fmt_err_o, bus.start_drop_o, bus.sample_o, bus.raw_o},
                  exp_vec());
        end
    end

    // Observation statistics gathered over a window of offsets from t0.
    int          o_cs_falls, o_cs_low_off, o_first_rise, o_rises, o_falls;
    int          o_valid_cnt, o_valid_off, o_drop_cnt, o_drop_off;
    int          o_busy_fall_off, o_fmt_cnt, o_fmt_with_valid, o_min_quiet;
    logic [11:0] o_sample;
    logic [15:0] o_raws[$];
    int          o_fall_offs[$];

    task automatic observe(input int t0, input int last_off);
        logic p_sck, p_cs_n, p_busy;
        int   off, run;
        bit   seen_low;
        o_cs_falls = 0; o_cs_low_off = -1; o_first_rise = -1; o_rises = 0; o_falls = 0;
        o_valid_cnt = 0; o_valid_off = -1; o_drop_cnt = 0; o_drop_off = -1;
        o_busy_fall_off = -1; o_fmt_cnt = 0; o_fmt_with_valid = 0; o_min_quiet = 100000;
        o_sample = 12'h000;
        o_raws.delete();
        o_fall_offs.delete();
        p_sck = 1'b0; p_cs_n = 1'b1; p_busy = 1'b0; run = 0; seen_low = 1'b0;
        off = cyc - 1 - t0;
        while (off <= last_off) begin
            if (p_cs_n && !bus.cs_n_o) begin
                o_cs_falls++;
                o_fall_offs.push_back(off);
                if (o_cs_low_off < 0) o_cs_low_off = off;
                if (seen_low && run > 0 && run < o_min_quiet) o_min_quiet = run;
                run = 0;
                seen_low = 1'b1;
            end else if (bus.cs_n_o && seen_low) begin
                run++;
            end
            if (!p_sck && bus.sck_o) begin
                o_rises++;
                if (o_first_rise < 0) o_first_rise = off;
            end
            if (p_sck && !bus.sck_o) o_falls++;
            if (bus.sample_valid_o) begin
                o_valid_cnt++;
                o_valid_off = off;
                o_sample = bus.sample_o;
                o_raws.push_back(bus.raw_o);
                if (bus.fmt_err_o) o_fmt_with_valid++;
            end
            if (bus.fmt_err_o) o_fmt_cnt++;
            if (bus.start_drop_o) begin
                o_drop_cnt++;
                o_drop_off = off;
            end
            if (p_busy && !bus.busy_o && o_busy_fall_off < 0) o_busy_fall_off = off;
            p_sck = bus.sck_o; p_cs_n = bus.cs_n_o; p_busy = bus.busy_o;
            @(negedge clk);
            off = cyc - 1 - t0;
        end
    endtask

    task automatic wait_edge(input int idx);
        while (cyc < idx) @(negedge clk);
    endtask

    // Drive start_i so that it is sampled at edge idx; returns after that edge.
    task automatic start_at(input int idx, output int t);
        wait_edge(idx);
        bus.start_i = 1'b1;
        t = cyc;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t_drop;
        bus.start_i = 1'b0;
`ifdef ADC_AUTO_TRIG_EN
        bus.auto_en_i = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_cs_n",  bus.cs_n_o, 1);
        check("rst_sck",   bus.sck_o, 0);
        check("rst_busy",  bus.busy_o, 0);
        check("rst_raw",   bus.raw_o, 0);
        check("rst_sample", bus.sample_o, 0);
        check("rst_valid", bus.sample_valid_o, 0);
        check("rst_fmt",   bus.fmt_err_o, 0);
        check("rst_drop",  bus.start_drop_o, 0);
        rst_i  = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);

        // Single frame 0x0AA5.
        adc_word = 16'h0AA5;
        start_at(cyc, t);
        observe(t, 150);
        check("f1_cs_low_off",  o_cs_low_off, 0);
        check("f1_first_rise",  o_first_rise, 8);
        check("f1_rises",       o_rises, 16);
        check("f1_falls",       o_falls, 16);
        check("f1_valid_cnt",   o_valid_cnt, 1);
        check("f1_valid_off",   o_valid_off, 132);
        check("f1_raw",         (o_raws.size() > 0) ? o_raws[0] : 16'hxxxx, 16'h0AA5);
        check("f1_sample",      o_sample, 12'hAA5);
        check("f1_fmt",         o_fmt_cnt, 0);
        check("f1_busy_fall",   o_busy_fall_off, 140);
        check("f1_drop",        o_drop_cnt, 0);

        // Back-to-back at the minimum start spacing.
        adc_word = 16'h0AA5;
        start_at(cyc, t);
        fork
            observe(t, 300);
            begin
                wait_edge(t + 135);
                adc_word = 16'h0AA6;
                start_at(t + FRAME + QC + 1, t_drop);
            end
        join
        check("b2b_frames",    o_cs_falls, 2);
        check("b2b_valid_cnt", o_valid_cnt, 2);
        check("b2b_raw0",      (o_raws.size() > 0) ? o_raws[0] : 16'hxxxx, 16'h0AA5);
        check("b2b_raw1",      (o_raws.size() > 1) ? o_raws[1] : 16'hxxxx, 16'h0AA6);
        check("b2b_quiet_ok",  o_min_quiet >= QC, 1);
        check("b2b_drop",      o_drop_cnt, 0);

        // Start reasserted mid-frame is dropped.
        adc_word = 16'h05A3;
        start_at(cyc, t);
        fork
            observe(t, 300);
            start_at(t + 50, t_drop);
        join
        check("mid_drop_cnt", o_drop_cnt, 1);
        check("mid_drop_off", o_drop_off, 50);
        check("mid_frames",   o_cs_falls, 1);
        check("mid_valid",    o_valid_cnt, 1);
        check("mid_sample",   o_sample, 12'h5A3);

        // Start on the QUIET exit edge is dropped as well.
        adc_word = 16'h0F0F;
        start_at(cyc, t);
        fork
            observe(t, 300);
            start_at(t + BUSY_LEN, t_drop);
        join
        check("qx_drop_off", o_drop_off, 140);
        check("qx_frames",   o_cs_falls, 1);
        check("qx_sample",   o_sample, 12'hF0F);

        // Nonzero leading nibble flags a format error with the valid.
        adc_word = 16'hF123;
        start_at(cyc, t);
        observe(t, 150);
        check("fmt_raw",        (o_raws.size() > 0) ? o_raws[0] : 16'hxxxx, 16'hF123);
        check("fmt_sample",     o_sample, 12'h123);
        check("fmt_with_valid", o_fmt_with_valid, 1);
        check("fmt_cnt",        o_fmt_cnt, 1);

        // Reset mid-frame aborts it and clears the sample.
        adc_word = 16'h0777;
        start_at(cyc, t);
        fork
            observe(t, 200);
            begin
                wait_edge(t + 70);
                rst_i = 1'b1;
                @(negedge clk);
                check("mrst_cs_n", bus.cs_n_o, 1);
                check("mrst_sck",  bus.sck_o, 0);
                check("mrst_raw",  bus.raw_o, 0);
                rst_i = 1'b0;
            end
        join
        check("mrst_no_valid", o_valid_cnt, 0);

        adc_word = 16'h0ABC;
        start_at(cyc, t);
        observe(t, 150);
        check("post_rst_valid",  o_valid_cnt, 1);
        check("post_rst_sample", o_sample, 12'hABC);

`ifdef ADC_AUTO_TRIG_EN
        // Automatic triggering every 200 cycles, then stop.
        chk_on = 1'b0;
        adc_word = 16'h0321;
        bus.auto_en_i = 1'b1;
        t = cyc;
        observe(t, 620);
        check("auto_frames", o_cs_falls, 3);
        check("auto_valids", o_valid_cnt, 2);
        if (o_fall_offs.size() >= 3) begin
            check("auto_first",   o_fall_offs[0], 200);
            check("auto_period1", o_fall_offs[1] - o_fall_offs[0], 200);
            check("auto_period2", o_fall_offs[2] - o_fall_offs[1], 200);
        end
        bus.auto_en_i = 1'b0;
        t = cyc;
        observe(t, 300);
        check("auto_stop_frames", o_cs_falls, 0);
        check("auto_stop_valid",  o_valid_cnt, 1);
        check("auto_stop_sample", o_sample, 12'h321);
`endif

        chk_on = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
